// File: rtl/iitb_fetch_pkg.sv
// rtl/iitb_fetch_pkg.sv - shared fetch-stage types and constants for IITB-RISC-23
package iitb_fetch_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pc_plus1;
    } if_id_t;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// rtl/instr_fetch_stage_if.sv - instruction memory read port between fetch and memory
interface instr_fetch_stage_if;
    import iitb_fetch_pkg::*;

    logic [WORD_W-1:0] ins_mem_access_addr;
    logic              ins_mem_read;
    logic [WORD_W-1:0] ins_mem_read_data;

    modport master (
        output ins_mem_access_addr,
        output ins_mem_read,
        input  ins_mem_read_data
    );

    modport slave (
        input  ins_mem_access_addr,
        input  ins_mem_read,
        output ins_mem_read_data
    );

endinterface

// File: rtl/fetch_if_id_reg.sv
// rtl/fetch_if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module fetch_if_id_reg
    import iitb_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // Flush inserts a bubble but keeps the pc fields of the last capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (!hold && load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - IITB-RISC-23 fetch stage: PC, fetch FSM, range halt, IF/ID
// Optional counters enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_stage
    import iitb_fetch_pkg::*;
#(
    parameter int                MEM_DEPTH = 256,
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_stage_if.master imem,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [WORD_W-1:0]   redirect_pc,
    output logic                if_id_valid,
    output logic [WORD_W-1:0]   if_id_instr,
    output logic [WORD_W-1:0]   if_id_pc,
    output logic [WORD_W-1:0]   if_id_pc_plus1,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt,
`endif
    output logic                fetch_halted
);

    localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] next_pc;
    logic [WORD_W-1:0] pc_inc;
    logic              read_q;
    logic              out_of_range;
    logic              reg_load;
    logic              reg_hold;
    logic              reg_flush;
    if_id_t            capture;
    if_id_t            if_id_q;

    assign pc_inc = pc + 16'd1;
    // A depth of 2^WORD_W can never be exceeded, which disables the check.
    assign out_of_range = ({{(32-WORD_W){1'b0}}, pc} >= DEPTH_U);

    assign capture = '{valid: 1'b1, instr: imem.ins_mem_read_data, pc: pc, pc_plus1: pc_inc};

    always_comb begin
        next_state = state;
        next_pc    = pc;
        reg_load   = 1'b0;
        reg_hold   = 1'b0;
        reg_flush  = 1'b0;
        if (redirect_valid) begin
            next_pc    = redirect_pc;
            next_state = RUN;
            reg_flush  = 1'b1;
        end else if (stall) begin
            reg_hold = 1'b1;
        end else begin
            case (state)
                IDLE: next_state = RUN;
                RUN: begin
                    if (out_of_range) begin
                        next_state = HALT;
                        reg_flush  = 1'b1;
                    end else begin
                        reg_load = 1'b1;
                        next_pc  = pc_inc;
                    end
                end
                HALT:    reg_flush = 1'b1;
                default: next_state = IDLE;
            endcase
        end
    end

    // Read enable and halt flag are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            read_q       <= 1'b0;
            fetch_halted <= 1'b0;
        end else begin
            state        <= next_state;
            pc           <= next_pc;
            read_q       <= (next_state == RUN);
            fetch_halted <= (next_state == HALT);
        end
    end

    fetch_if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (reg_load),
        .hold  (reg_hold),
        .flush (reg_flush),
        .d     (capture),
        .q     (if_id_q)
    );

    assign imem.ins_mem_access_addr = pc;
    assign imem.ins_mem_read        = read_q;
    assign if_id_valid    = if_id_q.valid;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus1 = if_id_q.pc_plus1;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (reg_load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall && state == RUN) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - self-checking bench for instr_fetch_stage (256-word and full-range instances)
module tb_instr_fetch_stage;
    import iitb_fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    logic        n_valid, w_valid, n_halted, w_halted;
    logic [15:0] n_instr, n_pc, n_plus1, w_instr, w_pc, w_plus1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] n_fcnt, n_scnt, w_fcnt, w_scnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    instr_fetch_stage_if bus_n ();
    instr_fetch_stage_if bus_w ();

    // Memory model: each word holds its own address.
    assign bus_n.ins_mem_read_data = bus_n.ins_mem_access_addr;
    assign bus_w.ins_mem_read_data = bus_w.ins_mem_access_addr;

    instr_fetch_stage #(.MEM_DEPTH(256), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem(bus_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(n_valid), .if_id_instr(n_instr), .if_id_pc(n_pc),
        .if_id_pc_plus1(n_plus1),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt(n_fcnt), .perf_stall_cnt(n_scnt),
`endif
        .fetch_halted(n_halted)
    );

    instr_fetch_stage #(.MEM_DEPTH(65536), .RESET_PC(16'h0000)) u_wide (
        .clk(clk), .rst_n(rst_n), .imem(bus_w), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(w_valid), .if_id_instr(w_instr), .if_id_pc(w_pc),
        .if_id_pc_plus1(w_plus1),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt(w_fcnt), .perf_stall_cnt(w_scnt),
`endif
        .fetch_halted(w_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({n_valid, n_instr, n_pc, n_plus1} !== {1'b0, 48'h0}) begin
            failures++; $display("FAIL reset_if_id got=%h exp=%h", {n_valid, n_instr, n_pc, n_plus1}, 49'h0);
        end
        checks++;
        if ({n_halted, bus_n.ins_mem_read, bus_n.ins_mem_access_addr} !== 18'h0) begin
            failures++; $display("FAIL reset_ctrl got=%h exp=%h", {n_halted, bus_n.ins_mem_read, bus_n.ins_mem_access_addr}, 18'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [15:0] e;
        tick();
        checks++;
        if ({bus_n.ins_mem_read, n_valid, bus_n.ins_mem_access_addr} !== {1'b1, 1'b0, 16'h0}) begin
            failures++; $display("FAIL idle_cycle got=%h exp=%h", {bus_n.ins_mem_read, n_valid, bus_n.ins_mem_access_addr}, {2'b10, 16'h0});
        end
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(16'(k));
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({n_valid, n_instr, n_pc, n_plus1} !== {1'b1, e, e, e + 16'd1}) begin
                failures++; $display("FAIL seq_capture got=%h exp=%h", {n_valid, n_instr, n_pc, n_plus1}, {1'b1, e, e, e + 16'd1});
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] e;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus_n.ins_mem_access_addr, n_pc, n_valid} !== {16'd5, 16'd4, 1'b1}) begin
                failures++; $display("FAIL stall_hold got=%h exp=%h", {bus_n.ins_mem_access_addr, n_pc, n_valid}, {16'd5, 16'd4, 1'b1});
            end
        end
        stall = 1'b0;
        exp_q.push_back(16'd5);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({n_valid, n_instr, n_pc} !== {1'b1, e, e}) begin
            failures++; $display("FAIL stall_release got=%h exp=%h", {n_valid, n_instr, n_pc}, {1'b1, e, e});
        end
    endtask

    task automatic test_redirect_stall();
        logic [15:0] e;
        redirect_valid = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        checks++;
        if ({bus_n.ins_mem_access_addr, n_valid, n_instr, n_pc, n_plus1} !== {16'h0040, 1'b0, 16'h0, 16'd5, 16'd6}) begin
            failures++; $display("FAIL redirect_bubble got=%h exp=%h", {bus_n.ins_mem_access_addr, n_valid, n_instr, n_pc, n_plus1}, {16'h0040, 1'b0, 16'h0, 16'd5, 16'd6});
        end
        exp_q.push_back(16'h0040);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({n_valid, n_instr, n_pc} !== {1'b1, e, e}) begin
            failures++; $display("FAIL redirect_capture got=%h exp=%h", {n_valid, n_instr, n_pc}, {1'b1, e, e});
        end
    endtask

    task automatic test_halt();
        logic [15:0] e;
        redirect_valid = 1'b1; redirect_pc = 16'h00FC;
        tick();
        redirect_valid = 1'b0;
        for (int k = 252; k < 256; k++) begin
            exp_q.push_back(16'(k));
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({n_valid, n_pc, n_halted} !== {1'b1, e, 1'b0}) begin
                failures++; $display("FAIL tail_capture got=%h exp=%h", {n_valid, n_pc, n_halted}, {1'b1, e, 1'b0});
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({n_halted, bus_n.ins_mem_read, n_valid, bus_n.ins_mem_access_addr} !== {3'b100, 16'h0100}) begin
                failures++; $display("FAIL halt_state got=%h exp=%h", {n_halted, bus_n.ins_mem_read, n_valid, bus_n.ins_mem_access_addr}, {3'b100, 16'h0100});
            end
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({n_halted, bus_n.ins_mem_read, n_valid, bus_n.ins_mem_access_addr} !== {3'b010, 16'h0010}) begin
            failures++; $display("FAIL halt_exit got=%h exp=%h", {n_halted, bus_n.ins_mem_read, n_valid, bus_n.ins_mem_access_addr}, {3'b010, 16'h0010});
        end
        exp_q.push_back(16'h0010);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({n_valid, n_instr, n_pc} !== {1'b1, e, e}) begin
            failures++; $display("FAIL halt_resume got=%h exp=%h", {n_valid, n_instr, n_pc}, {1'b1, e, e});
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({n_halted, bus_n.ins_mem_read, bus_n.ins_mem_access_addr} !== {2'b01, 16'h0200}) begin
            failures++; $display("FAIL oor_redirect_run got=%h exp=%h", {n_halted, bus_n.ins_mem_read, bus_n.ins_mem_access_addr}, {2'b01, 16'h0200});
        end
        tick();
        checks++;
        if ({n_halted, bus_n.ins_mem_read, n_valid} !== 3'b100) begin
            failures++; $display("FAIL oor_redirect_halt got=%h exp=%h", {n_halted, bus_n.ins_mem_read, n_valid}, 3'b100);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({bus_w.ins_mem_access_addr, w_valid} !== {16'hFFFF, 1'b0}) begin
            failures++; $display("FAIL wrap_redirect got=%h exp=%h", {bus_w.ins_mem_access_addr, w_valid}, {16'hFFFF, 1'b0});
        end
        tick();
        checks++;
        if ({w_valid, w_instr, w_pc, w_plus1, bus_w.ins_mem_access_addr} !== {1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000}) begin
            failures++; $display("FAIL wrap_top got=%h exp=%h", {w_valid, w_instr, w_pc, w_plus1, bus_w.ins_mem_access_addr}, {1'b1, 16'hFFFF, 16'hFFFF, 32'h0});
        end
        tick();
        checks++;
        if ({w_valid, w_pc, w_halted, bus_w.ins_mem_read} !== {1'b1, 16'h0000, 1'b0, 1'b1}) begin
            failures++; $display("FAIL wrap_zero got=%h exp=%h", {w_valid, w_pc, w_halted, bus_w.ins_mem_read}, {1'b1, 16'h0, 2'b01});
        end
    endtask

    task automatic test_async_reset();
        redirect_valid = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if ({n_valid, n_pc} !== {1'b1, 16'h0000}) begin
            failures++; $display("FAIL pre_reset_valid got=%h exp=%h", {n_valid, n_pc}, {1'b1, 16'h0});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({n_valid, n_instr, n_pc, n_plus1, n_halted, bus_n.ins_mem_read, bus_n.ins_mem_access_addr} !== 67'h0) begin
            failures++; $display("FAIL async_reset got=%h exp=%h", {n_valid, n_instr, n_pc, n_plus1, n_halted, bus_n.ins_mem_read, bus_n.ins_mem_access_addr}, 67'h0);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if ({n_fcnt, n_scnt, w_fcnt, w_scnt} !== 128'h0) begin
            failures++; $display("FAIL perf_reset got=%h exp=%h", {n_fcnt, n_scnt, w_fcnt, w_scnt}, 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        tick();
        checks++;
        if ({n_fcnt, n_scnt} !== {32'd2, 32'd2}) begin
            failures++; $display("FAIL perf_count got=%h exp=%h", {n_fcnt, n_scnt}, {32'd2, 32'd2});
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
